// File: rtl/ddr_arbiter.sv
// ddr_arbiter
//   Two-requester round-robin arbiter in front of a single burst-oriented DDR
//   controller port. One burst owns the DDR port at a time; arbitration only
//   happens between bursts.
//
// Ports
//   clock, reset             : single clock, synchronous active-high reset
//   inN_rd / inN_wr          : read-burst / write-beat request (N = 0, 1)
//   inN_addr, inN_burstLength: burst start address and beat count (0 means 1)
//   inN_mask, inN_din        : byte enables and write data of the current beat
//   inN_waitReq              : stall back to requester N
//   inN_valid, inN_dout      : read beat returned to requester N
//   inN_burstDone            : one-cycle pulse on the final beat of N's burst
//   io_ddr_*                 : command/data toward and from the DDR controller
module ddr_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in0_rd,
  input  logic                    in0_wr,
  input  logic [ADDR_WIDTH-1:0]   in0_addr,
  input  logic [7:0]              in0_burstLength,
  input  logic [DATA_WIDTH/8-1:0] in0_mask,
  input  logic [DATA_WIDTH-1:0]   in0_din,
  output logic                    in0_waitReq,
  output logic                    in0_valid,
  output logic [DATA_WIDTH-1:0]   in0_dout,
  output logic                    in0_burstDone,
  input  logic                    in1_rd,
  input  logic                    in1_wr,
  input  logic [ADDR_WIDTH-1:0]   in1_addr,
  input  logic [7:0]              in1_burstLength,
  input  logic [DATA_WIDTH/8-1:0] in1_mask,
  input  logic [DATA_WIDTH-1:0]   in1_din,
  output logic                    in1_waitReq,
  output logic                    in1_valid,
  output logic [DATA_WIDTH-1:0]   in1_dout,
  output logic                    in1_burstDone,
  output logic                    io_ddr_rd,
  output logic                    io_ddr_wr,
  output logic [ADDR_WIDTH-1:0]   io_ddr_addr,
  output logic [7:0]              io_ddr_burstLength,
  output logic [DATA_WIDTH/8-1:0] io_ddr_mask,
  output logic [DATA_WIDTH-1:0]   io_ddr_din,
  input  logic                    io_ddr_waitReq,
  input  logic                    io_ddr_valid,
  input  logic [DATA_WIDTH-1:0]   io_ddr_dout
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] READ      = 2'd1;
  localparam logic [1:0] READ_DATA = 2'd2;
  localparam logic [1:0] WRITE     = 2'd3;

  logic [1:0] state_q, state_d;
  logic       gnt_q, gnt_d;    // requester owning the current burst
  logic       last_q, last_d;  // requester granted most recently
  logic [7:0] cnt_q, cnt_d;    // beats completed in the current burst
  logic [7:0] len_q, len_d;    // beats expected in the current burst

  logic       req0, req1, win, win_rd;
  logic [7:0] win_len;
  logic       g_rd, g_wr;
  logic       cmd_phase, beat, last_beat, fwd;

  // Granted-port view used while a burst is in progress.
  assign g_rd = gnt_q ? in1_rd : in0_rd;
  assign g_wr = gnt_q ? in1_wr : in0_wr;

  // Round-robin: on a tie the requester that was not granted last wins.
  // last_q resets to 1 so in0 wins the first tie after reset.
  assign req0    = in0_rd | in0_wr;
  assign req1    = in1_rd | in1_wr;
  assign win     = (req0 & req1) ? ~last_q : req1;
  assign win_rd  = win ? in1_rd : in0_rd;
  assign win_len = win ? in1_burstLength : in0_burstLength;

  assign cmd_phase = (state_q == READ) || (state_q == WRITE);

  // A beat is a returned read word, or a write word the DDR side accepted.
  assign beat      = ((state_q == READ_DATA) && io_ddr_valid) ||
                     ((state_q == WRITE) && g_wr && !io_ddr_waitReq);
  assign last_beat = beat && ((cnt_q + 8'd1) == len_q);
  assign fwd       = (state_q == READ_DATA) && io_ddr_valid;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = win;
          last_d  = win;
          cnt_d   = 8'd0;
          // Length is captured at grant; the requester holds it stable
          // until its command is accepted, so this equals the accepted value.
          len_d   = (win_len == 8'd0) ? 8'd1 : win_len;
          state_d = win_rd ? READ : WRITE;
        end
      end
      READ: begin
        if (g_rd && !io_ddr_waitReq) begin
          cnt_d   = 8'd0;
          state_d = READ_DATA;
        end
      end
      default: begin
        if (beat) begin
          cnt_d = cnt_q + 8'd1;
          if (last_beat) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      len_q   <= 8'd1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Command side mirrors the owner; rd/wr strobes only in their command state.
  assign io_ddr_rd          = (state_q == READ) && g_rd;
  assign io_ddr_wr          = (state_q == WRITE) && g_wr;
  assign io_ddr_addr        = gnt_q ? in1_addr        : in0_addr;
  assign io_ddr_burstLength = gnt_q ? in1_burstLength : in0_burstLength;
  assign io_ddr_mask        = gnt_q ? in1_mask        : in0_mask;
  assign io_ddr_din         = gnt_q ? in1_din         : in0_din;

  // Only the owner in a command state sees the DDR stall; everyone else waits.
  assign in0_waitReq = !(cmd_phase && !gnt_q && !io_ddr_waitReq);
  assign in1_waitReq = !(cmd_phase &&  gnt_q && !io_ddr_waitReq);

  assign in0_valid     = fwd && !gnt_q;
  assign in1_valid     = fwd &&  gnt_q;
  assign in0_dout      = io_ddr_dout;
  assign in1_dout      = io_ddr_dout;
  assign in0_burstDone = last_beat && !gnt_q;
  assign in1_burstDone = last_beat &&  gnt_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
module tb_ddr_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in0_rd, in0_wr, in1_rd, in1_wr;
  logic [31:0] in0_addr, in1_addr;
  logic [7:0]  in0_burstLength, in1_burstLength;
  logic [7:0]  in0_mask, in1_mask;
  logic [63:0] in0_din, in1_din;
  logic        in0_waitReq, in0_valid, in0_burstDone;
  logic        in1_waitReq, in1_valid, in1_burstDone;
  logic [63:0] in0_dout, in1_dout;
  logic        io_ddr_rd, io_ddr_wr;
  logic [31:0] io_ddr_addr;
  logic [7:0]  io_ddr_burstLength;
  logic [7:0]  io_ddr_mask;
  logic [63:0] io_ddr_din;
  logic        io_ddr_waitReq, io_ddr_valid;
  logic [63:0] io_ddr_dout;

  ddr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
    .clock(clock), .reset(reset),
    .in0_rd(in0_rd), .in0_wr(in0_wr), .in0_addr(in0_addr),
    .in0_burstLength(in0_burstLength), .in0_mask(in0_mask), .in0_din(in0_din),
    .in0_waitReq(in0_waitReq), .in0_valid(in0_valid), .in0_dout(in0_dout),
    .in0_burstDone(in0_burstDone),
    .in1_rd(in1_rd), .in1_wr(in1_wr), .in1_addr(in1_addr),
    .in1_burstLength(in1_burstLength), .in1_mask(in1_mask), .in1_din(in1_din),
    .in1_waitReq(in1_waitReq), .in1_valid(in1_valid), .in1_dout(in1_dout),
    .in1_burstDone(in1_burstDone),
    .io_ddr_rd(io_ddr_rd), .io_ddr_wr(io_ddr_wr), .io_ddr_addr(io_ddr_addr),
    .io_ddr_burstLength(io_ddr_burstLength), .io_ddr_mask(io_ddr_mask),
    .io_ddr_din(io_ddr_din), .io_ddr_waitReq(io_ddr_waitReq),
    .io_ddr_valid(io_ddr_valid), .io_ddr_dout(io_ddr_dout)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- Reference model (burst-level view) ----------------
  // m_owner: -1 when the port is free, else the requester owning the burst.
  // m_cmd: a read whose command has not yet been accepted.
  // m_left: beats still to be completed in the burst.
  int   m_owner = -1;
  int   m_last  = 1;
  int   m_left  = 0;
  logic m_is_rd = 1'b0;
  logic m_cmd   = 1'b0;

  logic        tb_r0, tb_r1, tb_win;
  logic [7:0]  w_len;
  logic        own_rd, own_wr;
  logic [31:0] own_addr;
  logic [7:0]  own_len, own_mask;
  logic [63:0] own_din;
  assign tb_r0  = in0_rd | in0_wr;
  assign tb_r1  = in1_rd | in1_wr;
  assign tb_win = (tb_r0 && tb_r1) ? (m_last == 0) : tb_r1;
  assign w_len  = tb_win ? in1_burstLength : in0_burstLength;
  assign own_rd   = (m_owner == 1) ? in1_rd : in0_rd;
  assign own_wr   = (m_owner == 1) ? in1_wr : in0_wr;
  assign own_addr = (m_owner == 1) ? in1_addr : in0_addr;
  assign own_len  = (m_owner == 1) ? in1_burstLength : in0_burstLength;
  assign own_mask = (m_owner == 1) ? in1_mask : in0_mask;
  assign own_din  = (m_owner == 1) ? in1_din : in0_din;

  always @(posedge clock) begin
    if (reset) begin
      m_owner <= -1;
      m_last  <= 1;
    end else if (m_owner < 0) begin
      if (tb_r0 || tb_r1) begin
        m_owner <= tb_win ? 1 : 0;
        m_last  <= tb_win ? 1 : 0;
        m_is_rd <= tb_win ? in1_rd : in0_rd;
        m_left  <= (w_len == 8'd0) ? 1 : int'(w_len);
        m_cmd   <= 1'b1;
      end
    end else if (m_is_rd && m_cmd) begin
      if (own_rd && !io_ddr_waitReq) m_cmd <= 1'b0;
    end else if (m_is_rd) begin
      if (io_ddr_valid) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_owner <= -1;
      end
    end else begin
      if (own_wr && !io_ddr_waitReq) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_owner <= -1;
      end
    end
  end

  // Expected outputs derived from the model's burst view.
  logic m_idle, rcmd, rdat, wph, acc, fin;
  assign m_idle = (m_owner < 0);
  assign rcmd   = !m_idle && m_is_rd && m_cmd;
  assign rdat   = !m_idle && m_is_rd && !m_cmd;
  assign wph    = !m_idle && !m_is_rd;
  assign acc    = (rcmd || wph) && !io_ddr_waitReq;
  assign fin    = ((rdat && io_ddr_valid) || (wph && own_wr && !io_ddr_waitReq)) && (m_left == 1);

  always @(negedge clock) begin
    if (chk_en) begin
      chk1("io_ddr_rd", io_ddr_rd, rcmd && own_rd);
      chk1("io_ddr_wr", io_ddr_wr, wph && own_wr);
      chk1("in0_waitReq", in0_waitReq, !(acc && m_owner == 0));
      chk1("in1_waitReq", in1_waitReq, !(acc && m_owner == 1));
      chk1("in0_valid", in0_valid, rdat && io_ddr_valid && m_owner == 0);
      chk1("in1_valid", in1_valid, rdat && io_ddr_valid && m_owner == 1);
      chk1("in0_burstDone", in0_burstDone, fin && m_owner == 0);
      chk1("in1_burstDone", in1_burstDone, fin && m_owner == 1);
      if (rcmd || wph) begin
        chkw("io_ddr_addr", 64'(io_ddr_addr), 64'(own_addr));
        chkw("io_ddr_burstLength", 64'(io_ddr_burstLength), 64'(own_len));
        chkw("io_ddr_mask", 64'(io_ddr_mask), 64'(own_mask));
        chkw("io_ddr_din", io_ddr_din, own_din);
      end
      if (rdat && io_ddr_valid && m_owner == 0) chkw("in0_dout", in0_dout, io_ddr_dout);
      if (rdat && io_ddr_valid && m_owner == 1) chkw("in1_dout", in1_dout, io_ddr_dout);
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    in0_rd = 0; in0_wr = 0; in0_addr = '0; in0_burstLength = '0; in0_mask = '0; in0_din = '0;
    in1_rd = 0; in1_wr = 0; in1_addr = '0; in1_burstLength = '0; in1_mask = '0; in1_din = '0;
    io_ddr_waitReq = 0; io_ddr_valid = 0; io_ddr_dout = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic set_rw(input int p, input logic rd, input logic wr);
    if (p == 0) begin in0_rd = rd; in0_wr = wr; end
    else begin in1_rd = rd; in1_wr = wr; end
  endtask

  task automatic set_fields(input int p, input logic [31:0] a, input logic [7:0] l,
                            input logic [7:0] m, input logic [63:0] d);
    if (p == 0) begin in0_addr = a; in0_burstLength = l; in0_mask = m; in0_din = d; end
    else begin in1_addr = a; in1_burstLength = l; in1_mask = m; in1_din = d; end
  endtask

  task automatic set_din(input int p, input logic [63:0] d);
    if (p == 0) in0_din = d; else in1_din = d;
  endtask

  int   order[$];
  int   nb, accd, done_cnt;
  int   a_st[2];
  int   a_left[2];
  logic newdin[2];
  logic wq, bd, rdsel;
  logic [7:0] rlen;

  initial begin
    do_reset();
    chk_en = 1'b1;

    // Reset state, with a stray DDR valid that must not be forwarded.
    io_ddr_valid = 1'b1;
    @(negedge clock);
    chk1("rst_waitReq0", in0_waitReq, 1'b1);
    chk1("rst_waitReq1", in1_waitReq, 1'b1);
    chk1("rst_ddr_rd", io_ddr_rd, 1'b0);
    chk1("rst_ddr_wr", io_ddr_wr, 1'b0);
    chk1("rst_valid0", in0_valid, 1'b0);
    chk1("rst_valid1", in1_valid, 1'b0);
    chk1("rst_done1", in1_burstDone, 1'b0);
    tick();
    io_ddr_valid = 1'b0;

    // in1 read 0x1000 len 4.
    do_reset();
    set_fields(1, 32'h1000, 8'd4, 8'hFF, 64'h0);
    set_rw(1, 1'b1, 1'b0);
    @(negedge clock);
    chk1("r31_idle_rd", io_ddr_rd, 1'b0);
    tick();
    @(negedge clock);
    chk1("r31_cmd_rd", io_ddr_rd, 1'b1);
    chkw("r31_cmd_addr", 64'(io_ddr_addr), 64'h1000);
    tick();
    set_rw(1, 1'b0, 1'b0);
    nb = 0;
    for (int b = 0; b < 4; b++) begin
      io_ddr_valid = 1'b1;
      io_ddr_dout = 64'hA0 + 64'(b);
      @(negedge clock);
      if (in1_valid) nb++;
      chk1("r31_done", in1_burstDone, b == 3);
      tick();
    end
    io_ddr_valid = 1'b0;
    chkw("r31_beats", 64'(nb), 64'd4);

    // Simultaneous reads after reset: in0 first, in1 after in0 completes.
    do_reset();
    set_fields(0, 32'h100, 8'd2, 8'h0F, 64'h0);
    set_fields(1, 32'h200, 8'd2, 8'hF0, 64'h0);
    set_rw(0, 1'b1, 1'b0);
    set_rw(1, 1'b1, 1'b0);
    @(negedge clock);
    tick();
    @(negedge clock);
    chkw("r32_first_addr", 64'(io_ddr_addr), 64'h100);
    chk1("r32_in1_stalled", in1_waitReq, 1'b1);
    chk1("r32_model_owner0", m_owner == 0, 1'b1);
    tick();
    set_rw(0, 1'b0, 1'b0);
    for (int b = 0; b < 2; b++) begin
      io_ddr_valid = 1'b1;
      io_ddr_dout = 64'hB0 + 64'(b);
      @(negedge clock);
      chk1("r32_in0_done", in0_burstDone, b == 1);
      tick();
    end
    io_ddr_valid = 1'b0;
    @(negedge clock);
    tick();
    @(negedge clock);
    chkw("r32_second_addr", 64'(io_ddr_addr), 64'h200);
    chk1("r32_in1_accept", in1_waitReq, 1'b0);
    tick();
    set_rw(1, 1'b0, 1'b0);
    for (int b = 0; b < 2; b++) begin
      io_ddr_valid = 1'b1;
      @(negedge clock);
      chk1("r32_in1_done", in1_burstDone, b == 1);
      tick();
    end
    io_ddr_valid = 1'b0;

    // Both requesting len-1 reads continuously: grants alternate.
    do_reset();
    set_fields(0, 32'h10, 8'd1, 8'hFF, 64'h0);
    set_fields(1, 32'h20, 8'd1, 8'hFF, 64'h0);
    set_rw(0, 1'b1, 1'b0);
    set_rw(1, 1'b1, 1'b0);
    io_ddr_valid = 1'b1;
    order.delete();
    repeat (14) begin
      @(negedge clock);
      if (in0_burstDone) order.push_back(0);
      if (in1_burstDone) order.push_back(1);
      tick();
    end
    chk1("r33_count", order.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chkw("r33_order", 64'(order[i]), 64'(i % 2));
    clear_inputs();

    // in0 write len 2, DDR stalls the first beat for 3 cycles.
    do_reset();
    set_fields(0, 32'h300, 8'd2, 8'hF0, 64'h1111);
    set_rw(0, 1'b0, 1'b1);
    io_ddr_waitReq = 1'b1;
    @(negedge clock);
    chk1("r34_idle_wr", io_ddr_wr, 1'b0);
    accd = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clock);
      if (!in0_waitReq) accd++;
      chk1("r34_stall_done", in0_burstDone, 1'b0);
    end
    tick();
    io_ddr_waitReq = 1'b0;
    @(negedge clock);
    if (!in0_waitReq) accd++;
    chk1("r34_beat1_done", in0_burstDone, 1'b0);
    tick();
    set_din(0, 64'h2222);
    @(negedge clock);
    if (!in0_waitReq) accd++;
    chk1("r34_beat2_done", in0_burstDone, 1'b1);
    chkw("r34_beat2_din", io_ddr_din, 64'h2222);
    tick();
    set_rw(0, 1'b0, 1'b0);
    @(negedge clock);
    chkw("r34_accepted", 64'(accd), 64'd2);
    chk1("r34_model_idle", m_owner < 0, 1'b1);

    // Reset after 2 of 4 read beats; late DDR valids are dropped.
    do_reset();
    set_fields(0, 32'h40, 8'd4, 8'hFF, 64'h0);
    set_rw(0, 1'b1, 1'b0);
    @(negedge clock);
    tick();
    @(negedge clock);
    tick();
    set_rw(0, 1'b0, 1'b0);
    repeat (2) begin
      io_ddr_valid = 1'b1;
      @(negedge clock);
      tick();
    end
    reset = 1'b1;
    @(negedge clock);
    tick();
    reset = 1'b0;
    repeat (2) begin
      io_ddr_valid = 1'b1;
      @(negedge clock);
      chk1("r35_valid0", in0_valid, 1'b0);
      chk1("r35_valid1", in1_valid, 1'b0);
      chk1("r35_wait0", in0_waitReq, 1'b1);
      chk1("r35_wait1", in1_waitReq, 1'b1);
      chk1("r35_model_idle", m_owner < 0, 1'b1);
      tick();
    end
    io_ddr_valid = 1'b0;

    // in1 read with burstLength 0 behaves as a single beat.
    do_reset();
    set_fields(1, 32'h500, 8'd0, 8'hFF, 64'h0);
    set_rw(1, 1'b1, 1'b0);
    @(negedge clock);
    tick();
    @(negedge clock);
    chkw("r36_len_mirror", 64'(io_ddr_burstLength), 64'd0);
    tick();
    set_rw(1, 1'b0, 1'b0);
    io_ddr_valid = 1'b1;
    io_ddr_dout = 64'hBEEF;
    @(negedge clock);
    chk1("r36_valid", in1_valid, 1'b1);
    chk1("r36_done", in1_burstDone, 1'b1);
    chkw("r36_dout", in1_dout, 64'hBEEF);
    tick();
    @(negedge clock);
    chk1("r36_after_valid", in1_valid, 1'b0);
    tick();
    io_ddr_valid = 1'b0;

    // Randomized traffic from two well-behaved requesters.
    do_reset();
    a_st[0] = 0; a_st[1] = 0; a_left[0] = 0; a_left[1] = 0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      for (int p = 0; p < 2; p++) begin
        wq = (p == 0) ? in0_waitReq : in1_waitReq;
        bd = (p == 0) ? in0_burstDone : in1_burstDone;
        newdin[p] = 1'b0;
        case (a_st[p])
          1: if (!wq) a_st[p] = 2;
          2: if (bd) begin a_st[p] = 0; done_cnt++; end
          3: if (!wq) begin
               a_left[p]--;
               newdin[p] = 1'b1;
               if (a_left[p] == 0) begin a_st[p] = 0; done_cnt++; end
             end
          default: ;
        endcase
      end
      tick();
      io_ddr_waitReq = ($urandom % 3) == 0;
      io_ddr_valid   = ($urandom % 2) == 0;
      io_ddr_dout    = {$urandom, $urandom};
      for (int p = 0; p < 2; p++) begin
        if (a_st[p] == 0) begin
          if (($urandom % 3) == 0) begin
            rlen  = 8'($urandom_range(0, 5));
            rdsel = ($urandom % 2) == 0;
            set_fields(p, $urandom, rlen, 8'($urandom_range(0, 255)), {$urandom, $urandom});
            if (rdsel) begin
              a_st[p] = 1;
              set_rw(p, 1'b1, ($urandom % 4) == 0);
            end else begin
              a_st[p] = 3;
              a_left[p] = (rlen == 8'd0) ? 1 : int'(rlen);
              set_rw(p, 1'b0, 1'b1);
            end
          end else begin
            set_rw(p, 1'b0, 1'b0);
          end
        end else if (a_st[p] == 2) begin
          set_rw(p, 1'b0, 1'b0);
        end else if (a_st[p] == 3 && newdin[p]) begin
          set_din(p, {$urandom, $urandom});
        end
      end
    end
    chk1("rand_progress", done_cnt > 50, 1'b1);

    clear_inputs();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_arbiter.md
DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width on all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data beat width; mask width is DATA_WIDTH/8.
REQ-003 SHALL have port clock  in  1  single clock for all logic.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports inN_rd  in  1  read-burst request, N=0,1.
REQ-006 SHALL have ports inN_wr  in  1  write-beat request, N=0,1.
REQ-007 SHALL have ports inN_addr  in  ADDR_WIDTH  burst start address, N=0,1.
REQ-008 SHALL have ports inN_burstLength  in  8  beats in burst, N=0,1.
REQ-009 SHALL have ports inN_mask  in  DATA_WIDTH/8  byte enables, N=0,1.
REQ-010 SHALL have ports inN_din  in  DATA_WIDTH  write data, N=0,1.
REQ-011 SHALL have ports inN_waitReq  out  1  stall; request not accepted, N=0,1.
REQ-012 SHALL have ports inN_valid / inN_dout  out  1 / DATA_WIDTH  read beat to requester N.
REQ-013 SHALL have ports inN_burstDone  out  1  one-cycle pulse on final beat of requester N's burst.
REQ-014 SHALL have ports io_ddr_rd, io_ddr_wr, io_ddr_addr, io_ddr_burstLength, io_ddr_mask, io_ddr_din  out  to DDR.
REQ-015 SHALL have ports io_ddr_waitReq, io_ddr_valid, io_ddr_dout  in  from DDR.

Function
REQ-016 SHALL implement states IDLE, READ, READ_DATA, WRITE.
REQ-017 IDLE: if any inN_rd|inN_wr is high, SHALL register the grant and enter READ (rd set) or WRITE (otherwise) next cycle; rd wins if a requester asserts both.
REQ-018 Arbitration SHALL be round-robin: the requester not granted last wins on simultaneous requests; after reset in0 has priority.
REQ-019 In IDLE, io_ddr_rd=io_ddr_wr=0, both inN_waitReq=1, no inN_valid forwarded; requesters hold requests until accepted.
REQ-020 In READ/WRITE, io_ddr_addr/burstLength/mask/din/rd/wr SHALL combinationally mirror the granted port; granted inN_waitReq=io_ddr_waitReq; other port waitReq=1.
REQ-021 Latency: first DDR command cycle is exactly one clock after the request is first seen in IDLE.
REQ-022 READ: on io_ddr_rd & !io_ddr_waitReq, SHALL latch burst length into an 8-bit beat counter and enter READ_DATA; io_ddr_rd deasserts in READ_DATA.
REQ-023 READ_DATA: each io_ddr_valid SHALL drive granted inN_valid=1 and inN_dout=io_ddr_dout in the same cycle and increment the counter.
REQ-024 WRITE: only beats with io_ddr_wr & !io_ddr_waitReq SHALL be counted; stalled beats are not counted.
REQ-025 On the beat making count equal burst length, SHALL pulse inN_burstDone that cycle and return to IDLE next cycle.
REQ-026 burstLength 0 SHALL be treated as 1; maximum 255 beats, no counter wrap.
REQ-027 io_ddr_valid outside READ_DATA SHALL be ignored and not forwarded.
REQ-028 Requests arriving during a burst SHALL wait; arbitration happens only in IDLE.

Reset
REQ-029 On reset: state IDLE, counter 0, round-robin pointer favours in0, io_ddr_rd=io_ddr_wr=0, inN_waitReq=1, inN_valid=0, inN_burstDone=0.
REQ-030 Reset mid-burst SHALL abandon the burst; late DDR valid beats after reset are dropped per REQ-027.

Verification
REQ-031 in1 read addr 0x1000 len 4, no waitReq -> io_ddr_rd one cycle later with addr 0x1000; 4 in1_valid beats; in1_burstDone on 4th beat.
REQ-032 in0 and in1 read requests in same cycle after reset -> in0 served first, in1 starts after in0_burstDone.
REQ-033 Both requesters continuously requesting len 1 reads -> grants alternate in0, in1, in0, in1.
REQ-034 in0 write len 2 with io_ddr_waitReq high 3 cycles on beat 1 -> exactly 2 accepted beats counted, in0_burstDone on 2nd accepted beat.
REQ-035 Reset after 2 of 4 read beats, DDR then returns 2 valids -> no inN_valid, both waitReq=1, state IDLE.
REQ-036 in1 read with burstLength 0 -> one beat returned, in1_burstDone on that beat.
